grad_dac_spi_mc: RTL and testbench
==================================

GRAD_DAC_SPI_MC -- requirements
Module: grad_dac_spi_mc

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of DAC channels (legal 1..8), each driven by its own serial data line.
REQ-002 SHALL provide parameter DW, default 24, the DAC word width in bits (legal 8..28).
REQ-003 SHALL provide parameter DIVW, default 8, the width of the SPI clock divider input.
REQ-004 SHALL provide port clk, input, 1 bit, system clock.
REQ-005 SHALL provide port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL provide port data_i, input, 32 bits: [DW-1:0] payload, [28] commit flag, [31:29] channel index.
REQ-007 SHALL provide port valid_i, input, 1 bit, which qualifies data_i for one clk cycle per word.
REQ-008 SHALL provide port spi_clk_div_i, input, DIVW bits, the SPI half-period minus 1, in clk cycles.
REQ-009 SHALL provide port busy_o, output, 1 bit, high while a frame or a pending frame exists.
REQ-010 SHALL provide port data_lost_o, output, 1 bit, a sticky overrun flag.
REQ-011 SHALL provide ports sclk_o, syncn_o and ldacn_o, outputs, 1 bit each, driving the shared SPI clock, the frame select and the load strobe.
REQ-012 SHALL provide port sdo_o, output, NCH bits, one serial data line per channel.

Function
REQ-013 SHALL write each valid_i word into the shadow register of its channel index; an index of NCH or above SHALL discard the payload only.
REQ-014 SHALL, for a valid_i word with the commit flag set, copy all shadow registers (including that word's own payload) into the transmit registers on the same edge when IDLE, and start a frame.
REQ-015 SHALL, on a commit while a frame is active, set a one-deep pending flag; the snapshot SHALL be taken when the current frame ends.
REQ-016 SHALL, on a commit while the pending flag is already set, set data_lost_o and leave the existing pending flag in place.
REQ-017 SHALL implement the state machine IDLE -> SETUP -> SHIFT -> HOLD -> LOAD -> IDLE; LOAD SHALL go to SETUP instead of IDLE when the pending flag is set, and SHALL clear that flag.
REQ-018 SHALL define the half-period H as spi_clk_div_i+1 clk cycles, sampled at frame start and held constant for the frame.
REQ-019 SHALL hold the SETUP state for H cycles, with syncn_o low and sclk_o high.
REQ-020 SHALL, in SHIFT, shift DW bits MSB first on every sdo_o line in parallel, with data changing on sclk_o rising edges and stable across falling edges.
REQ-021 SHALL give each sclk_o phase exactly H cycles, and SHALL end SHIFT after DW falling edges.
REQ-022 SHALL hold the HOLD state for H cycles, raising syncn_o at HOLD entry.
REQ-023 SHALL drive ldacn_o low for H cycles in LOAD.
REQ-024 SHALL drive syncn_o low on the clk edge after the accepted commit edge.
REQ-025 SHALL make a frame last (2*DW+3)*H cycles from syncn_o falling to the end of LOAD.
REQ-026 SHALL assert busy_o from the commit edge until IDLE is re-entered with no pending flag.
REQ-027 SHALL clear data_lost_o only by reset.
REQ-028 SHALL accept a spi_clk_div_i of 0, giving H=1 and an sclk_o of clk/2.
REQ-029 SHALL make spi_clk_div_i changes mid-frame take effect only at the next frame.

Reset
REQ-030 SHALL, while rst is high, force IDLE and zero all shadow and transmit registers, the pending flag, busy_o and data_lost_o.
REQ-031 SHALL, while rst is high, drive sclk_o=1, syncn_o=1, ldacn_o=1 and sdo_o=0.
REQ-032 SHALL, on a reset mid-frame, abort the frame with no LOAD pulse, and SHALL accept a new commit on the first clk edge after rst falls.

Configuration
REQ-033 SHALL, with GRAD_DAC_SPI_LDAC_EN defined, behave as above.
REQ-034 SHALL, with GRAD_DAC_SPI_LDAC_EN undefined, omit the LOAD state, go from HOLD directly to IDLE or SETUP, and tie ldacn_o to 0 so DACs update on syncn_o rising, giving a frame length of (2*DW+2)*H cycles.

Verification
REQ-035 SHALL check, with NCH=4, DW=24, div=3 and LDAC_EN: write 0x100004, 0x100008, 0x10000C to ch0..2, then 0x100010 with commit to ch3 -> syncn_o low 1 cycle after commit, 24 falling edges, each line shows its word MSB first, ldacn_o low for 4 cycles, frame 204 cycles.
REQ-036 SHALL check back-to-back commits: a second commit 20 cycles into a frame -> a second frame starts right after LOAD, data_lost_o stays 0, and busy_o is continuous.
REQ-037 SHALL check overrun: three commits within one frame -> data_lost_o=1 after the third, and only two frames are sent, the second carrying the second snapshot.
REQ-038 SHALL check a channel index of 5 with NCH=4 and payload 0xABCDEF -> no register changes; with commit set, a frame carries the prior shadow values.
REQ-039 SHALL check a div=0 frame followed by rst pulsed at cycle 10 -> all outputs at reset values, no ldacn_o pulse, busy_o=0, data_lost_o=0.
REQ-040 SHALL check, with GRAD_DAC_SPI_LDAC_EN undefined and div=3: one commit -> ldacn_o constantly 0 and a frame of 200 cycles.

Source files
------------

// File: rtl/grad_dac_spi_mc.sv
`default_nettype none
// ============================================================================
//  Module      : grad_dac_spi_mc
//  Description : Multi-channel serial DAC driver. Words are written into
//                per-channel shadow registers; a commit snapshots every shadow
//                into the transmit registers and sends one frame on a shared
//                sclk/syncn, with one sdo line per channel shifted in
//                parallel. Optional LDAC load strobe is enabled by defining
//                the macro GRAD_DAC_SPI_LDAC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_dac_spi_mc #(
    parameter int NCH  = 4,
    parameter int DW   = 24,
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     data_i,
    input  logic            valid_i,
    input  logic [DIVW-1:0] spi_clk_div_i,
    output logic            busy_o,
    output logic            data_lost_o,
    output logic            sclk_o,
    output logic            syncn_o,
    output logic            ldacn_o,
    output logic [NCH-1:0]  sdo_o
);

    localparam int              c_BITW = $clog2(DW);
    localparam logic [c_BITW-1:0] c_LAST = c_BITW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_LOAD  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DIVW-1:0]   r_div;
    logic [DIVW-1:0]   r_cnt;
    logic [c_BITW-1:0] r_bit;
    logic              r_phase;
    logic              r_pending;
    logic              r_lost;
    logic              r_busy;
    logic              r_sclk;
    logic              r_syncn;
    logic [NCH-1:0]    r_sdo;
    logic [NCH-1:0]    w_sdo;
    logic              w_commit;
    logic [2:0]        w_idx;
    logic              w_tick;
    logic              w_frame_end;
    logic              w_start;
    logic              w_restart;
    logic              w_load;
    logic              w_in_frame;
    logic              w_unused;

    assign w_commit   = valid_i & data_i[28];
    assign w_idx      = data_i[31:29];
    assign w_tick     = (r_cnt == '0);
    assign w_in_frame = (r_state == S_SETUP) || (r_state == S_SHIFT);
    assign w_unused   = ^(data_i[27:0] >> DW);

`ifdef GRAD_DAC_SPI_LDAC_EN
    assign w_frame_end = (r_state == S_LOAD) && w_tick;
`else
    assign w_frame_end = (r_state == S_HOLD) && w_tick;
`endif

    // A commit arriving on the very edge a frame ends with nothing pending
    // starts the next frame directly instead of being parked as pending.
    assign w_start   = w_commit && ((r_state == S_IDLE) || (w_frame_end && !r_pending));
    assign w_restart = w_frame_end && r_pending;
    assign w_load    = w_start || w_restart;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; every non-idle state lasts whole half-periods
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_SETUP;
            S_SETUP: if (w_tick) w_state_next = S_SHIFT;
            S_SHIFT: if (w_tick && r_phase && (r_bit == c_LAST)) w_state_next = S_HOLD;
`ifdef GRAD_DAC_SPI_LDAC_EN
            S_HOLD:  if (w_tick) w_state_next = S_LOAD;
            S_LOAD:  if (w_tick) w_state_next = w_load ? S_SETUP : S_IDLE;
`else
            S_HOLD:  if (w_tick) w_state_next = w_load ? S_SETUP : S_IDLE;
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Half-period counter; the divider is latched only when a frame starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_div <= spi_clk_div_i;
            r_cnt <= spi_clk_div_i;
        end else if (w_tick) begin
            r_cnt <= r_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // SCLK phase (0 = low half) and bit index within SHIFT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else if (w_load) begin
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else if ((r_state == S_SHIFT) && w_tick) begin
            r_phase <= ~r_phase;
            if (r_phase) r_bit <= r_bit + 1'b1;
        end
    end

    // Pending commit and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_lost    <= 1'b0;
        end else if (w_restart) begin
            r_pending <= w_commit;
        end else if (w_commit && !w_start) begin
            if (r_pending) r_lost    <= 1'b1;
            else           r_pending <= 1'b1;
        end
    end

    // Busy covers the commit edge through the final return to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= 1'b0;
        else     r_busy <= (w_state_next != S_IDLE);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] r_shadow;
        logic [DW-1:0] r_tx;
        logic [DW-1:0] w_shadow_next;

        // Out-of-range channel indices never match, so their payload is dropped
        always_comb begin
            w_shadow_next = r_shadow;
            if (valid_i && (w_idx == 3'(i))) w_shadow_next = data_i[DW-1:0];
        end

        // Shadow register write
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_shadow <= '0;
            else     r_shadow <= w_shadow_next;
        end

        // Transmit register: snapshot on frame start, shift on each SCLK rise
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_tx <= '0;
            else if (w_load)
                r_tx <= w_shadow_next;
            else if ((r_state == S_SHIFT) && w_tick && !r_phase)
                r_tx <= {r_tx[DW-2:0], 1'b0};
        end

        assign w_sdo[i] = r_tx[DW-1];
    end

    // Registered pin drivers, one cycle behind the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk  <= 1'b1;
            r_syncn <= 1'b1;
            r_sdo   <= '0;
        end else begin
            r_sclk  <= (r_state == S_SHIFT) ? r_phase : 1'b1;
            r_syncn <= ~w_in_frame;
            r_sdo   <= w_in_frame ? w_sdo : '0;
        end
    end

`ifdef GRAD_DAC_SPI_LDAC_EN
    logic r_ldacn;

    // Load strobe low for the whole LOAD state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ldacn <= 1'b1;
        else     r_ldacn <= (r_state != S_LOAD);
    end

    assign ldacn_o = r_ldacn;
`else
    assign ldacn_o = 1'b0;
`endif

    assign busy_o      = r_busy;
    assign data_lost_o = r_lost;
    assign sclk_o      = r_sclk;
    assign syncn_o     = r_syncn;
    assign sdo_o       = r_sdo;

endmodule
`default_nettype wire

// File: tb/tb_grad_dac_spi_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grad_dac_spi_mc
//  Description : Self-checking bench for grad_dac_spi_mc (NCH=4, DW=24).
//                Honours GRAD_DAC_SPI_LDAC_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grad_dac_spi_mc;
    localparam int NCH = 4;
    localparam int DW  = 24;
`ifdef GRAD_DAC_SPI_LDAC_EN
    localparam int FR_MULT = 2*DW + 3;
`else
    localparam int FR_MULT = 2*DW + 2;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    data_i = '0;
    logic           valid_i = 1'b0;
    logic [7:0]     spi_clk_div_i = '0;
    logic           busy_o, data_lost_o, sclk_o, syncn_o, ldacn_o;
    logic [NCH-1:0] sdo_o;

    grad_dac_spi_mc #(.NCH(NCH), .DW(DW), .DIVW(8)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .spi_clk_div_i(spi_clk_div_i), .busy_o(busy_o), .data_lost_o(data_lost_o),
        .sclk_o(sclk_o), .syncn_o(syncn_o), .ldacn_o(ldacn_o), .sdo_o(sdo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] w0, w1, w2, w3;
        int            nfall;
        int            low_len;
        int            fall_cyc;
    } frm_t;

    typedef struct {
        logic [2:0]    ch;
        logic          commit;
        logic [DW-1:0] pay;
        int            div;
        logic [DW-1:0] e0, e1, e2, e3;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   commit_cyc = 0;
    frm_t frames[$];

    // Monitor state
    logic          prev_sclk = 1'b1, prev_syncn = 1'b1, prev_busy = 1'b0;
    logic [DW-1:0] cap [NCH];
    int            nfall = 0, low_len = 0, fall_cyc = 0;
    int            busy_hi = 0, busy_rise = 0, ldac_lo = 0, win = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame capture: sample sdo on every sclk fall while syncn is low
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk  <= 1'b1;
            prev_syncn <= 1'b1;
            prev_busy  <= 1'b0;
        end else begin
            prev_sclk  <= sclk_o;
            prev_syncn <= syncn_o;
            prev_busy  <= busy_o;
            win        <= win + 1;
            busy_hi    <= busy_hi + int'(busy_o);
            ldac_lo    <= ldac_lo + int'(!ldacn_o);
            if (busy_o && !prev_busy) busy_rise <= busy_rise + 1;
            if (prev_syncn && !syncn_o) begin
                nfall    <= 0;
                low_len  <= 1;
                fall_cyc <= cyc;
                for (int i = 0; i < NCH; i++) cap[i] <= '0;
            end else if (!syncn_o) begin
                low_len <= low_len + 1;
                if (prev_sclk && !sclk_o) begin
                    nfall <= nfall + 1;
                    for (int i = 0; i < NCH; i++) cap[i] <= {cap[i][DW-2:0], sdo_o[i]};
                end
            end
            if (!prev_syncn && syncn_o)
                frames.push_back('{cap[0], cap[1], cap[2], cap[3], nfall, low_len, fall_cyc});
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] ch, input logic commit, input logic [DW-1:0] pay,
                        input int div);
        @(negedge clk);
        data_i        = {ch, commit, 4'b0, pay};
        valid_i       = 1'b1;
        spi_clk_div_i = 8'(div);
        @(negedge clk);
        valid_i    = 1'b0;
        data_i     = '0;
        commit_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'b0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_words(input string nm, input frm_t f, input logic [DW-1:0] e0,
                               input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                               input logic [DW-1:0] e3);
        check({nm, "_ch0"}, 32'(f.w0), 32'(e0));
        check({nm, "_ch1"}, 32'(f.w1), 32'(e1));
        check({nm, "_ch2"}, 32'(f.w2), 32'(e2));
        check({nm, "_ch3"}, 32'(f.w3), 32'(e3));
    endtask

    vec_t vt [9];

    initial begin
        int b_busy, b_ldac, b_win, b_fr, b_rise, h;
        frm_t f, g;

        vt[0] = '{3'd0, 1'b0, 24'h100004, 3, '0, '0, '0, '0};
        vt[1] = '{3'd1, 1'b0, 24'h100008, 3, '0, '0, '0, '0};
        vt[2] = '{3'd2, 1'b0, 24'h10000C, 3, '0, '0, '0, '0};
        vt[3] = '{3'd3, 1'b1, 24'h100010, 3, 24'h100004, 24'h100008, 24'h10000C, 24'h100010};
        vt[4] = '{3'd5, 1'b1, 24'hABCDEF, 3, 24'h100004, 24'h100008, 24'h10000C, 24'h100010};
        vt[5] = '{3'd0, 1'b1, 24'hFFFFFF, 0, 24'hFFFFFF, 24'h100008, 24'h10000C, 24'h100010};
        vt[6] = '{3'd7, 1'b0, 24'h123456, 0, '0, '0, '0, '0};
        vt[7] = '{3'd2, 1'b1, 24'hA5A5A5, 1, 24'hFFFFFF, 24'h100008, 24'hA5A5A5, 24'h100010};
        vt[8] = '{3'd1, 1'b1, 24'h000001, 2, 24'hFFFFFF, 24'h000001, 24'hA5A5A5, 24'h100010};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sclk",  {31'b0, sclk_o},  32'd1);
        check("rst_syncn", {31'b0, syncn_o}, 32'd1);
`ifdef GRAD_DAC_SPI_LDAC_EN
        check("rst_ldacn", {31'b0, ldacn_o}, 32'd1);
`else
        check("rst_ldacn", {31'b0, ldacn_o}, 32'd0);
`endif
        check("rst_sdo",   {28'b0, sdo_o},   32'd0);
        check("rst_busy",  {31'b0, busy_o},  32'd0);
        check("rst_lost",  {31'b0, data_lost_o}, 32'd0);
        rst = 1'b0;

        // Table-driven writes and single-commit frames
        for (int i = 0; i < 9; i++) begin
            b_busy = busy_hi; b_ldac = ldac_lo; b_win = win; b_fr = frames.size();
            send(vt[i].ch, vt[i].commit, vt[i].pay, vt[i].div);
            wait_idle(3000);
            h = vt[i].div + 1;
            if (vt[i].commit) begin
                check("frame_count", 32'(frames.size() - b_fr), 32'd1);
                if (frames.size() > b_fr) begin
                    f = frames[b_fr];
                    check("syncn_delay", 32'(f.fall_cyc - commit_cyc), 32'd1);
                    check("fall_edges", 32'(f.nfall), 32'(DW));
                    check_words("vec", f, vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3);
                    check("syncn_low_len", 32'(f.low_len), 32'((2*DW + 1) * h));
                end
                check("busy_len", 32'(busy_hi - b_busy), 32'(FR_MULT * h));
`ifdef GRAD_DAC_SPI_LDAC_EN
                check("ldacn_low_len", 32'(ldac_lo - b_ldac), 32'(h));
`else
                check("ldacn_tied_low", 32'(ldac_lo - b_ldac), 32'(win - b_win));
`endif
                check("lost_clear", {31'b0, data_lost_o}, 32'd0);
            end else begin
                check("no_frame", 32'(frames.size() - b_fr), 32'd0);
                check("no_busy", 32'(busy_hi - b_busy), 32'd0);
            end
        end

        // Back-to-back: second commit 20 cycles in, with a new divider
        b_busy = busy_hi; b_rise = busy_rise; b_fr = frames.size();
        send(3'd0, 1'b1, 24'h111111, 3);
        repeat (19) @(negedge clk);
        send(3'd1, 1'b1, 24'h222222, 1);
        wait_idle(3000);
        check("b2b_frames", 32'(frames.size() - b_fr), 32'd2);
        if (frames.size() >= b_fr + 2) begin
            f = frames[b_fr];
            g = frames[b_fr + 1];
            check_words("b2b_f1", f, 24'h111111, 24'h000001, 24'hA5A5A5, 24'h100010);
            check_words("b2b_f2", g, 24'h111111, 24'h222222, 24'hA5A5A5, 24'h100010);
            check("b2b_f1_low", 32'(f.low_len), 32'((2*DW + 1) * 4));
            check("b2b_f2_low", 32'(g.low_len), 32'((2*DW + 1) * 2));
            check("b2b_gap", 32'(g.fall_cyc - f.fall_cyc), 32'(FR_MULT * 4));
        end
        check("b2b_busy_len", 32'(busy_hi - b_busy), 32'(FR_MULT * 6));
        check("b2b_busy_once", 32'(busy_rise - b_rise), 32'd1);
        check("b2b_lost", {31'b0, data_lost_o}, 32'd0);

        // Overrun: three commits in one frame, third to an invalid channel
        b_fr = frames.size();
        send(3'd0, 1'b1, 24'h0A0A0A, 3);
        repeat (10) @(negedge clk);
        send(3'd0, 1'b1, 24'h0B0B0B, 3);
        check("ovr_lost_after2", {31'b0, data_lost_o}, 32'd0);
        repeat (10) @(negedge clk);
        send(3'd6, 1'b1, 24'h0C0C0C, 3);
        check("ovr_lost_after3", {31'b0, data_lost_o}, 32'd1);
        wait_idle(3000);
        check("ovr_frames", 32'(frames.size() - b_fr), 32'd2);
        if (frames.size() >= b_fr + 2) begin
            check_words("ovr_f1", frames[b_fr], 24'h0A0A0A, 24'h222222, 24'hA5A5A5, 24'h100010);
            check_words("ovr_f2", frames[b_fr + 1], 24'h0B0B0B, 24'h222222, 24'hA5A5A5, 24'h100010);
        end
        check("ovr_lost_sticky", {31'b0, data_lost_o}, 32'd1);

        // Reset mid-frame at div=0, then commit on the first edge after release
        send(3'd3, 1'b1, 24'h777777, 0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sclk",  {31'b0, sclk_o},  32'd1);
        check("mid_rst_syncn", {31'b0, syncn_o}, 32'd1);
`ifdef GRAD_DAC_SPI_LDAC_EN
        check("mid_rst_ldacn", {31'b0, ldacn_o}, 32'd1);
`else
        check("mid_rst_ldacn", {31'b0, ldacn_o}, 32'd0);
`endif
        check("mid_rst_sdo",   {28'b0, sdo_o},   32'd0);
        check("mid_rst_busy",  {31'b0, busy_o},  32'd0);
        check("mid_rst_lost",  {31'b0, data_lost_o}, 32'd0);
        repeat (2) @(negedge clk);
        b_fr = frames.size(); b_ldac = ldac_lo;
        rst           = 1'b0;
        data_i        = {3'd1, 1'b1, 4'b0, 24'h5A5A5A};
        valid_i       = 1'b1;
        spi_clk_div_i = 8'd3;
        @(negedge clk);
        valid_i    = 1'b0;
        data_i     = '0;
        commit_cyc = cyc;
        check("post_rst_busy", {31'b0, busy_o}, 32'd1);
        wait_idle(3000);
        check("post_rst_frames", 32'(frames.size() - b_fr), 32'd1);
        if (frames.size() > b_fr) begin
            f = frames[b_fr];
            check("post_rst_delay", 32'(f.fall_cyc - commit_cyc), 32'd1);
            check_words("post_rst", f, 24'h0, 24'h5A5A5A, 24'h0, 24'h0);
        end
`ifdef GRAD_DAC_SPI_LDAC_EN
        check("post_rst_ldac", 32'(ldac_lo - b_ldac), 32'd4);
`endif
        check("post_rst_lost", {31'b0, data_lost_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
